// File: rtl/shift_rows_pipe.sv
// Pipelined Rijndael ShiftRows/InvShiftRows for NB = 4/6/8 columns with valid/ready backpressure.
// Optional output-transfer counter port beat_cnt when SHIFT_ROWS_BEAT_CNT_EN is defined.
module shift_rows_pipe #(
  parameter int NB     = 4,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_inv,
  input  logic [32*NB-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_inv,
  output logic [32*NB-1:0]  out_data
`ifdef SHIFT_ROWS_BEAT_CNT_EN
  ,
  output logic [31:0]       beat_cnt
`endif
);
  localparam int W = 32 * NB;

  generate
    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
      $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("shift_rows_pipe: STAGES must be in 1..4");
    end
  endgenerate

  function automatic int shamt(input int r);
    case (r)
      0:       return 0;
      1:       return 1;
      2:       return (NB == 8) ? 3 : 2;
      default: return (NB == 8) ? 4 : 3;
    endcase
  endfunction

  logic [W-1:0] w_fwd, w_inv, w_shift;

  // Pure byte routing: both directions are fixed wiring, selected per beat.
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int SF = (c + shamt(r)) % NB;
      localparam int SI = (c + NB - shamt(r)) % NB;
      assign w_fwd[W-1-8*(4*c+r) -: 8] = in_data[W-1-8*(4*SF+r) -: 8];
      assign w_inv[W-1-8*(4*c+r) -: 8] = in_data[W-1-8*(4*SI+r) -: 8];
    end
  end

  assign w_shift = in_inv ? w_inv : w_fwd;

  logic [STAGES-1:0]        r_vld_pipe, r_inv;
  logic [STAGES-1:0][W-1:0] r_data;
  logic [STAGES-1:0]        w_rdy, w_vin, w_iin;
  logic [STAGES-1:0][W-1:0] w_din;

  // A stage can load if it or any later stage has a hole, or the sink drains.
  always_comb begin
    w_vin    = '0;
    w_iin    = '0;
    w_din    = '0;
    w_vin[0] = in_valid;
    w_iin[0] = in_inv;
    w_din[0] = w_shift;
    for (int k = 1; k < STAGES; k++) begin
      w_vin[k] = r_vld_pipe[k-1];
      w_iin[k] = r_inv[k-1];
      w_din[k] = r_data[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      w_rdy[k] = out_ready;
      for (int j = k; j < STAGES; j++)
        if (!r_vld_pipe[j]) w_rdy[k] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_inv      <= '0;
      r_data     <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_rdy[k]) begin
          r_vld_pipe[k] <= w_vin[k];
          if (w_vin[k]) begin
            r_inv[k]  <= w_iin[k];
            r_data[k] <= w_din[k];
          end
        end
      end
    end
  end

  assign in_ready  = w_rdy[0];
  assign out_valid = r_vld_pipe[STAGES-1];
  assign out_inv   = r_inv[STAGES-1];
  assign out_data  = r_data[STAGES-1];

`ifdef SHIFT_ROWS_BEAT_CNT_EN
  logic [31:0] r_beat_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_beat_cnt <= '0;
    else if (out_valid && out_ready) r_beat_cnt <= r_beat_cnt + 32'd1;
  end
  assign beat_cnt = r_beat_cnt;
`endif
endmodule

// File: tb/tb_shift_rows_pipe.sv
// Bench for shift_rows_pipe: three configurations checked against a row-rotation reference model.
module tb_shift_rows_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  localparam logic [127:0] FIPS_IN  = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;
  localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;

  // A: NB=4 STAGES=1, B: NB=8 STAGES=2, C: NB=4 STAGES=4
  logic a_in_valid, a_in_ready, a_in_inv, a_out_valid, a_out_ready, a_out_inv;
  logic [127:0] a_in_data, a_out_data;
  logic b_in_valid, b_in_ready, b_in_inv, b_out_valid, b_out_ready, b_out_inv;
  logic [255:0] b_in_data, b_out_data;
  logic c_in_valid, c_in_ready, c_in_inv, c_out_valid, c_out_ready, c_out_inv;
  logic [127:0] c_in_data, c_out_data;
`ifdef SHIFT_ROWS_BEAT_CNT_EN
  logic [31:0] a_cnt, b_cnt, c_cnt;
`endif

  shift_rows_pipe #(.NB(4), .STAGES(1)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_inv(a_in_inv),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_inv(a_out_inv),
    .out_data(a_out_data)
`ifdef SHIFT_ROWS_BEAT_CNT_EN
    , .beat_cnt(a_cnt)
`endif
  );
  shift_rows_pipe #(.NB(8), .STAGES(2)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inv(b_in_inv),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_inv(b_out_inv),
    .out_data(b_out_data)
`ifdef SHIFT_ROWS_BEAT_CNT_EN
    , .beat_cnt(b_cnt)
`endif
  );
  shift_rows_pipe #(.NB(4), .STAGES(4)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_inv(c_in_inv),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_inv(c_out_inv),
    .out_data(c_out_data)
`ifdef SHIFT_ROWS_BEAT_CNT_EN
    , .beat_cnt(c_cnt)
`endif
  );

  // Reference: lift each row into a list of NB bytes and rotate it s(r) places.
  function automatic logic [255:0] ref_shift(input logic [255:0] d, input int nb, input bit inv);
    logic [7:0]   q[$];
    logic [255:0] o;
    int           s;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      s = (r == 0) ? 0 : (r == 1) ? 1 : (r == 2) ? ((nb == 8) ? 3 : 2) : ((nb == 8) ? 4 : 3);
      q.delete();
      for (int c = 0; c < nb; c++) q.push_back(d[32*nb-1-8*(4*c+r) -: 8]);
      for (int i = 0; i < s; i++) begin
        if (!inv) q.push_back(q.pop_front());
        else      q.push_front(q.pop_back());
      end
      for (int c = 0; c < nb; c++) o[32*nb-1-8*(4*c+r) -: 8] = q[c];
    end
    return o;
  endfunction

  task automatic test_reset();
    a_in_valid = 0; a_in_inv = 0; a_in_data = '0; a_out_ready = 1;
    b_in_valid = 0; b_in_inv = 0; b_in_data = '0; b_out_ready = 1;
    c_in_valid = 0; c_in_inv = 0; c_in_data = '0; c_out_ready = 1;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({a_out_valid, a_out_inv, a_in_ready} !== 3'b001 || a_out_data !== '0) begin
      errors++; $display("FAIL reset_a: got v=%b i=%b r=%b d=%h want 0 0 1 0", a_out_valid, a_out_inv, a_in_ready, a_out_data); end
    checks++; if ({b_out_valid, b_out_inv, b_in_ready} !== 3'b001 || b_out_data !== '0) begin
      errors++; $display("FAIL reset_b: got v=%b i=%b r=%b d=%h want 0 0 1 0", b_out_valid, b_out_inv, b_in_ready, b_out_data); end
    checks++; if ({c_out_valid, c_out_inv, c_in_ready} !== 3'b001 || c_out_data !== '0) begin
      errors++; $display("FAIL reset_c: got v=%b i=%b r=%b d=%h want 0 0 1 0", c_out_valid, c_out_inv, c_in_ready, c_out_data); end
    @(negedge clk) rst = 0;
    @(negedge clk);
    checks++; if ({a_in_ready, b_in_ready, c_in_ready, a_out_valid, b_out_valid, c_out_valid} !== 6'b111000) begin
      errors++; $display("FAIL idle_after_reset: got rdy=%b%b%b vld=%b%b%b want 111 000",
        a_in_ready, b_in_ready, c_in_ready, a_out_valid, b_out_valid, c_out_valid); end
`ifdef SHIFT_ROWS_BEAT_CNT_EN
    checks++; if (a_cnt !== 32'd0) begin errors++; $display("FAIL cnt_reset: got %0d want 0", a_cnt); end
`endif
  endtask

`ifdef SHIFT_ROWS_BEAT_CNT_EN
  task automatic test_beat_cnt();
    int sent = 0, got = 0, cyc = 0;
    while (got < 5 && cyc < 40) begin
      @(posedge clk); #1;
      a_in_valid  = (sent < 5);
      a_in_inv    = 0;
      a_in_data   = {$urandom, $urandom, $urandom, $urandom};
      a_out_ready = !(cyc == 2 || cyc == 3);
      @(negedge clk);
      if (a_out_valid && a_out_ready) got++;
      if (a_in_valid && a_in_ready) sent++;
      cyc++;
    end
    a_in_valid = 0; a_out_ready = 1;
    @(negedge clk);
    checks++; if (got != 5) begin errors++; $display("FAIL cnt_transfers: got %0d want 5", got); end
    checks++; if (a_cnt !== 32'd5) begin errors++; $display("FAIL beat_cnt: got %0d want 5", a_cnt); end
  endtask
`endif

  task automatic test_fips();
    @(posedge clk); #1;
    a_out_ready = 1; a_in_valid = 1; a_in_inv = 0; a_in_data = FIPS_IN;
    @(posedge clk); #1;
    checks++; if (a_out_valid !== 1 || a_out_data !== FIPS_OUT || a_out_inv !== 0) begin
      errors++; $display("FAIL fips_fwd: got v=%b i=%b d=%h want 1 0 %h", a_out_valid, a_out_inv, a_out_data, FIPS_OUT); end
    a_in_inv = 1; a_in_data = FIPS_OUT;
    @(posedge clk); #1;
    a_in_valid = 0; a_in_data = '1;
    checks++; if (a_out_valid !== 1 || a_out_data !== FIPS_IN || a_out_inv !== 1) begin
      errors++; $display("FAIL fips_inv_b2b: got v=%b i=%b d=%h want 1 1 %h", a_out_valid, a_out_inv, a_out_data, FIPS_IN); end
    @(posedge clk); #1;
    checks++; if (a_out_valid !== 0 || a_out_data !== FIPS_IN) begin
      errors++; $display("FAIL fips_idle: got v=%b d=%h want 0 %h", a_out_valid, a_out_data, FIPS_IN); end
  endtask

  task automatic test_latency_inv();
    @(posedge clk); #1;
    c_out_ready = 1; c_in_valid = 1; c_in_inv = 1; c_in_data = FIPS_OUT;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (i == 1) c_in_valid = 0;
      if (i < 4) begin
        checks++; if (c_out_valid !== 0) begin errors++; $display("FAIL lat4_early: cycle %0d got v=%b want 0", i, c_out_valid); end
      end else begin
        checks++; if (c_out_valid !== 1 || c_out_data !== FIPS_IN || c_out_inv !== 1) begin
          errors++; $display("FAIL lat4_inv: got v=%b i=%b d=%h want 1 1 %h", c_out_valid, c_out_inv, c_out_data, FIPS_IN); end
      end
    end
  endtask

  task automatic test_nb8();
    logic [255:0] din, exp;
    for (int k = 0; k < 32; k++) din[255-8*k -: 8] = 8'(k);
    exp = ref_shift(din, 8, 0);
    for (int pass = 0; pass < 2; pass++) begin
      @(posedge clk); #1;
      b_out_ready = 1; b_in_valid = 1; b_in_inv = (pass == 1); b_in_data = (pass == 0) ? din : exp;
      @(posedge clk); #1;
      b_in_valid = 0;
      checks++; if (b_out_valid !== 0) begin errors++; $display("FAIL nb8_lat: pass %0d got v=%b want 0", pass, b_out_valid); end
      @(posedge clk); #1;
      if (pass == 0) begin
        checks++; if (b_out_valid !== 1 || b_out_data !== exp || b_out_inv !== 0) begin
          errors++; $display("FAIL nb8_fwd: got v=%b d=%h want 1 %h", b_out_valid, b_out_data, exp); end
        checks++; if (b_out_data[255:224] !== 32'h00050e13 || b_out_data[31:0] !== 32'h1c010a0f) begin
          errors++; $display("FAIL nb8_edge_cols: got %h..%h want 00050e13..1c010a0f", b_out_data[255:224], b_out_data[31:0]); end
      end else begin
        checks++; if (b_out_valid !== 1 || b_out_data !== din || b_out_inv !== 1) begin
          errors++; $display("FAIL nb8_roundtrip: got v=%b d=%h want 1 %h", b_out_valid, b_out_data, din); end
      end
    end
  endtask

  task automatic test_stream_stall();
    logic [127:0] exp_q[$];
    logic         inv_q[$];
    logic [255:0] tmp;
    logic [127:0] cur, prev_d;
    logic         prev_i;
    int sent = 0, got = 0, cyc = 0;
    bit saw_full = 0, prev_stall = 0;
    cur = {$urandom, $urandom, $urandom, $urandom};
    while (got < 10 && cyc < 80) begin
      @(posedge clk); #1;
      c_in_valid  = (sent < 10);
      c_in_inv    = sent[0];
      c_in_data   = cur;
      c_out_ready = !(cyc >= 4 && cyc < 10);
      @(negedge clk);
      checks++; if (c_in_ready !== ((exp_q.size() < 4) || c_out_ready)) begin
        errors++; $display("FAIL stream_in_ready: cycle %0d got %b with %0d held", cyc, c_in_ready, exp_q.size()); end
      if (!c_in_ready) saw_full = 1;
      if (prev_stall) begin
        checks++; if (c_out_valid !== 1 || c_out_data !== prev_d || c_out_inv !== prev_i) begin
          errors++; $display("FAIL stall_hold: got v=%b i=%b d=%h want 1 %b %h", c_out_valid, c_out_inv, c_out_data, prev_i, prev_d); end
      end
      prev_stall = c_out_valid && !c_out_ready;
      prev_d = c_out_data;
      prev_i = c_out_inv;
      if (c_out_valid && c_out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stream_extra: got unexpected beat %h", c_out_data);
        end else begin
          if (c_out_data !== exp_q[0] || c_out_inv !== inv_q[0]) begin
            errors++; $display("FAIL stream_beat%0d: got i=%b d=%h want %b %h", got, c_out_inv, c_out_data, inv_q[0], exp_q[0]); end
          void'(exp_q.pop_front());
          void'(inv_q.pop_front());
        end
        got++;
      end
      if (c_in_valid && c_in_ready) begin
        tmp = ref_shift({128'd0, cur}, 4, c_in_inv);
        exp_q.push_back(tmp[127:0]);
        inv_q.push_back(c_in_inv);
        sent++;
        cur = {$urandom, $urandom, $urandom, $urandom};
      end
      cyc++;
    end
    c_in_valid = 0; c_out_ready = 1;
    checks++; if (got != 10) begin errors++; $display("FAIL stream_count: got %0d want 10", got); end
    checks++; if (!saw_full) begin errors++; $display("FAIL stream_backpressure: in_ready got never-low want low when full"); end
  endtask

  task automatic test_reset_flight();
    logic [255:0] tmp;
    logic [127:0] d;
    c_out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      c_in_valid = 1; c_in_inv = i[0]; c_in_data = {$urandom, $urandom, $urandom, $urandom} | 128'h1;
    end
    @(posedge clk); #1;
    c_in_valid = 0;
    checks++; if (c_out_valid !== 1 || c_in_ready !== 0) begin
      errors++; $display("FAIL flight_full: got v=%b r=%b want 1 0", c_out_valid, c_in_ready); end
    @(negedge clk); #1;
    rst = 1;
    #1;
    checks++; if (c_out_valid !== 0 || c_out_data !== '0 || c_out_inv !== 0 || c_in_ready !== 1) begin
      errors++; $display("FAIL async_reset: got v=%b i=%b r=%b d=%h want 0 0 1 0", c_out_valid, c_out_inv, c_in_ready, c_out_data); end
    @(negedge clk);
    rst = 0; c_out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (c_out_valid !== 0) begin errors++; $display("FAIL stale_beat: cycle %0d got v=%b want 0", i, c_out_valid); end
    end
    d = {$urandom, $urandom, $urandom, $urandom};
    tmp = ref_shift({128'd0, d}, 4, 0);
    @(posedge clk); #1;
    c_in_valid = 1; c_in_inv = 0; c_in_data = d;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (i == 1) c_in_valid = 0;
      checks++; if (c_out_valid !== (i == 4)) begin
        errors++; $display("FAIL post_reset_lat: cycle %0d got v=%b want %b", i, c_out_valid, (i == 4)); end
    end
    checks++; if (c_out_data !== tmp[127:0] || c_out_inv !== 0) begin
      errors++; $display("FAIL post_reset_data: got %h want %h", c_out_data, tmp[127:0]); end
  endtask

  initial begin
    test_reset();
`ifdef SHIFT_ROWS_BEAT_CNT_EN
    test_beat_cnt();
`endif
    test_fips();
    test_latency_inv();
    test_nb8();
    test_stream_stall();
    test_reset_flight();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
